// File: rtl/vga_timing_ctrl.sv
`timescale 1ns/1ps
// vga_timing_ctrl: 640x480@60 display timing from the board clock.
// A clock divider produces the pixel-rate tick that advances the horizontal
// and vertical counters. Every output is registered together from the
// counters, so the sync and visible flags, the coordinates and the gated
// colour all change on the same clk.
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output logic       h_sync,
  output logic       v_sync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       Red,
  output logic       Green,
  output logic       Blue
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // A one-clk divider still needs a 1-bit counter; it simply stays at zero.
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             tick_d1;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_last;
  logic             v_last;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic             vis_d;
  logic             hs_d;
  logic             vs_d;
  logic             fs_d;

  // Pixel-rate tick on the last clk of each divider period.
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
  end

  // Clock divider: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Horizontal counter advances once per pixel tick and wraps at end of line.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Vertical counter advances on each line wrap and wraps at end of frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_cnt <= '0;
    end else if (tick && h_last) begin
      if (v_last) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  // Tick delayed one clk so pixel_tick lines up with the registered coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_d1 <= 1'b0;
    end else begin
      tick_d1 <= tick;
    end
  end

  // Two-flop synchroniser for the asynchronous colour switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {red, green, blue};
      sync2 <= sync1;
    end
  end

  // Decode of the current counter position into next-output values.
  always_comb begin
    vis_d = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_d  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_d  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    fs_d  = tick_d1 && (h_cnt == '0) && (v_cnt == '0);
  end

  // Output register; colour is gated by the visible flag registered in the same clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      Red         <= 1'b0;
      Green       <= 1'b0;
      Blue        <= 1'b0;
    end else begin
      h_sync      <= hs_d;
      v_sync      <= vs_d;
      video_on    <= vis_d;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      pixel_tick  <= tick_d1;
      frame_start <= fs_d;
      Red         <= sync2[2] & vis_d;
      Green       <= sync2[1] & vis_d;
      Blue        <= sync2[0] & vis_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
`timescale 1ns/1ps
// Bench for vga_timing_ctrl: three instances (default timing at /4 and /1,
// plus a shrunken frame at /2 so whole frames fit in a short run) checked
// every clk against a closed-form timing model through per-instance queues,
// with scenario tasks adding targeted timing measurements.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vo;
    logic [9:0] x;
    logic [9:0] y;
    logic       pt;
    logic       fs;
    logic [2:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1, rst1 = 1'b1, rsts = 1'b1;
  logic red = 1'b0, green = 1'b0, blue = 1'b0;

  logic       h_sync4, v_sync4, video_on4, pixel_tick4, frame_start4, Red4, Green4, Blue4;
  logic [9:0] pixel_x4, pixel_y4;
  logic       h_sync1, v_sync1, video_on1, pixel_tick1, frame_start1, Red1, Green1, Blue1;
  logic [9:0] pixel_x1, pixel_y1;
  logic       h_syncs, v_syncs, video_ons, pixel_ticks, frame_starts, Reds, Greens, Blues;
  logic [9:0] pixel_xs, pixel_ys;

  vga_timing_ctrl #(.CLK_DIV(4)) u4 (
    .clk(clk), .reset(rst4), .red(red), .green(green), .blue(blue),
    .h_sync(h_sync4), .v_sync(v_sync4), .video_on(video_on4),
    .pixel_x(pixel_x4), .pixel_y(pixel_y4), .pixel_tick(pixel_tick4),
    .frame_start(frame_start4), .Red(Red4), .Green(Green4), .Blue(Blue4));

  vga_timing_ctrl #(.CLK_DIV(1)) u1 (
    .clk(clk), .reset(rst1), .red(red), .green(green), .blue(blue),
    .h_sync(h_sync1), .v_sync(v_sync1), .video_on(video_on1),
    .pixel_x(pixel_x1), .pixel_y(pixel_y1), .pixel_tick(pixel_tick1),
    .frame_start(frame_start1), .Red(Red1), .Green(Green1), .Blue(Blue1));

  vga_timing_ctrl #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) us (
    .clk(clk), .reset(rsts), .red(red), .green(green), .blue(blue),
    .h_sync(h_syncs), .v_sync(v_syncs), .video_on(video_ons),
    .pixel_x(pixel_xs), .pixel_y(pixel_ys), .pixel_tick(pixel_ticks),
    .frame_start(frame_starts), .Red(Reds), .Green(Greens), .Blue(Blues));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int unsigned k4 = 0, k1 = 0, ks = 0;
  obs_t q4[$], q1[$], qs[$];
  logic [2:0] swq[$];

  // Expected outputs after the k-th edge since reset release, from a closed form.
  function automatic obs_t model(int unsigned d, int unsigned hv, int unsigned hf,
                                 int unsigned hsw, int unsigned hb, int unsigned vv,
                                 int unsigned vf, int unsigned vsw, int unsigned vb,
                                 int unsigned k, logic rst, logic [2:0] sw2);
    obs_t e;
    int unsigned ht, vt, n, x, y;
    e = '0;
    if (rst) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
    end
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    n = k / d;
    x = n % ht;
    y = (n / ht) % vt;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.vo  = (x < hv) && (y < vv);
    e.hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
    e.vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
    e.pt  = (k >= 1) && (k % d == 0);
    e.fs  = e.pt && (x == 0) && (y == 0);
    e.rgb = (k >= 2 && e.vo) ? sw2 : 3'b000;
    return e;
  endfunction

  function automatic obs_t obs4();
    return obs_t'({h_sync4, v_sync4, video_on4, pixel_x4, pixel_y4, pixel_tick4, frame_start4, Red4, Green4, Blue4});
  endfunction
  function automatic obs_t obs1();
    return obs_t'({h_sync1, v_sync1, video_on1, pixel_x1, pixel_y1, pixel_tick1, frame_start1, Red1, Green1, Blue1});
  endfunction
  function automatic obs_t obss();
    return obs_t'({h_syncs, v_syncs, video_ons, pixel_xs, pixel_ys, pixel_ticks, frame_starts, Reds, Greens, Blues});
  endfunction

  // One clk: push expectations for the coming edge, advance, pop and compare.
  task automatic tick_sb();
    logic [2:0] sw2;
    obs_t got, exp;
    swq.push_back({red, green, blue});
    if (swq.size() > 3) void'(swq.pop_front());
    sw2 = (swq.size() == 3) ? swq[0] : 3'b000;
    q4.push_back(model(4, 640, 16, 96, 48, 480, 10, 2, 33, k4, rst4, sw2));
    q1.push_back(model(1, 640, 16, 96, 48, 480, 10, 2, 33, k1, rst1, sw2));
    qs.push_back(model(2, 8, 2, 3, 2, 4, 2, 2, 3, ks, rsts, sw2));
    @(posedge clk);
    #1;
    cyc++;
    got = obs4(); exp = q4.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sb_u4 cyc=%0d k=%0d got=%h expected=%h", cyc, k4, got, exp);
    end
    got = obs1(); exp = q1.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sb_u1 cyc=%0d k=%0d got=%h expected=%h", cyc, k1, got, exp);
    end
    got = obss(); exp = qs.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sb_us cyc=%0d k=%0d got=%h expected=%h", cyc, ks, got, exp);
    end
    k4 = rst4 ? 0 : k4 + 1;
    k1 = rst1 ? 0 : k1 + 1;
    ks = rsts ? 0 : ks + 1;
  endtask

  task automatic test_reset();
    obs_t rv;
    rv = '0; rv.hs = 1'b1; rv.vs = 1'b1;
    {red, green, blue} = 3'b110;
    rst4 = 1'b1; rst1 = 1'b1; rsts = 1'b1;
    repeat (3) tick_sb();
    n_checks++;
    if (obs4() !== rv) begin
      n_fail++;
      $display("FAIL reset_values got=%h expected=%h", obs4(), rv);
    end
    rst4 = 1'b0; rst1 = 1'b0; rsts = 1'b0;
    tick_sb();
    n_checks++;
    if ({pixel_x4, pixel_y4, video_on4, h_sync4, v_sync4} !== {10'd0, 10'd0, 3'b111}) begin
      n_fail++;
      $display("FAIL first_clk x=%0d y=%0d vo=%b hs=%b vs=%b expected 0 0 1 1 1",
               pixel_x4, pixel_y4, video_on4, h_sync4, v_sync4);
    end
    tick_sb();
    n_checks++;
    if ({Red4, Green4, Blue4} !== 3'b000) begin
      n_fail++;
      $display("FAIL rgb_clk2 got=%b expected=000", {Red4, Green4, Blue4});
    end
    tick_sb();
    n_checks++;
    if ({Red4, Green4, Blue4} !== 3'b110) begin
      n_fail++;
      $display("FAIL rgb_clk3 got=%b expected=110", {Red4, Green4, Blue4});
    end
  endtask

  task automatic test_line_timing();
    int last_pt = -1, bad_pt = 0, bad_step = 0, prev_x;
    int hs_start = -1, hs_runs = 0, bad_hs = 0;
    int last_wrap = -1, lines = 0, bad_line = 0;
    logic hs_prev;
    {red, green, blue} = 3'b111;
    prev_x = int'(pixel_x4);
    hs_prev = h_sync4;
    repeat (7000) begin
      tick_sb();
      if (pixel_tick4) begin
        if (last_pt >= 0 && cyc - last_pt != 4) bad_pt++;
        if (int'(pixel_x4) != ((prev_x == 799) ? 0 : prev_x + 1)) bad_step++;
        last_pt = cyc;
        prev_x = int'(pixel_x4);
        if (pixel_x4 == 10'd0) begin
          if (last_wrap >= 0 && cyc - last_wrap != 3200) bad_line++;
          last_wrap = cyc;
          lines++;
        end
      end else if (int'(pixel_x4) != prev_x) begin
        bad_step++;
      end
      if (hs_prev && !h_sync4) begin
        hs_start = cyc;
        if (pixel_x4 != 10'd656) bad_hs++;
      end
      if (!hs_prev && h_sync4 && hs_start >= 0) begin
        hs_runs++;
        if (cyc - hs_start != 384) bad_hs++;
      end
      hs_prev = h_sync4;
    end
    n_checks++;
    if (bad_pt != 0 || last_pt < 0) begin
      n_fail++;
      $display("FAIL tick_period bad_intervals=%0d required=0", bad_pt);
    end
    n_checks++;
    if (bad_step != 0) begin
      n_fail++;
      $display("FAIL x_step bad_steps=%0d required=0", bad_step);
    end
    n_checks++;
    if (bad_hs != 0 || hs_runs < 2) begin
      n_fail++;
      $display("FAIL hsync_pulse bad=%0d runs=%0d required bad=0 runs>=2", bad_hs, hs_runs);
    end
    n_checks++;
    if (bad_line != 0 || lines < 2) begin
      n_fail++;
      $display("FAIL line_len bad=%0d lines=%0d required bad=0 lines>=2", bad_line, lines);
    end
  endtask

  task automatic test_rgb_boundary();
    logic [2:0] prev_rgb;
    logic [9:0] prev_x;
    logic found = 1'b0, seen_vis = 1'b0, seen_edge = 1'b0;
    int bad_blank = 0;
    {red, green, blue} = 3'b111;
    prev_rgb = {Red4, Green4, Blue4};
    prev_x = pixel_x4;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick_sb();
      if (pixel_tick4 && pixel_x4 == 10'd640) begin
        found = 1'b1;
        n_checks++;
        if (prev_x !== 10'd639 || prev_rgb !== 3'b111) begin
          n_fail++;
          $display("FAIL rgb_x639 x=%0d rgb=%b required x=639 rgb=111", prev_x, prev_rgb);
        end
        n_checks++;
        if ({Red4, Green4, Blue4, video_on4} !== 4'b0000) begin
          n_fail++;
          $display("FAIL rgb_x640 rgb=%b vo=%b required 000 0", {Red4, Green4, Blue4}, video_on4);
        end
      end
      prev_rgb = {Red4, Green4, Blue4};
      prev_x = pixel_x4;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_x640 found=0 required=1");
    end
    repeat (400) begin
      tick_sb();
      if (pixel_ys >= 10'd4 && {Reds, Greens, Blues} !== 3'b000) bad_blank++;
      if (pixel_ys == 10'd3 && pixel_xs == 10'd7 && {Reds, Greens, Blues} === 3'b111) seen_vis = 1'b1;
      if (pixel_ticks && pixel_ys == 10'd4 && pixel_xs == 10'd0) begin
        seen_edge = 1'b1;
        if ({Reds, Greens, Blues, video_ons} !== 4'b0000) bad_blank++;
      end
    end
    n_checks++;
    if (bad_blank != 0 || !seen_vis || !seen_edge) begin
      n_fail++;
      $display("FAIL v_blank_rgb bad=%0d seen_vis=%b seen_edge=%b required 0 1 1",
               bad_blank, seen_vis, seen_edge);
    end
  endtask

  task automatic test_green_toggle();
    logic found = 1'b0;
    int fall_at = -1, bad_rb = 0;
    {red, green, blue} = 3'b111;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick_sb();
      if (pixel_tick4 && pixel_x4 == 10'd100 && video_on4) found = 1'b1;
    end
    n_checks++;
    if (!found || Green4 !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_x100 found=%b green=%b required 1 1", found, Green4);
    end
    green = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick_sb();
      if (Green4 === 1'b0 && fall_at < 0) fall_at = i;
      if (Red4 !== 1'b1 || Blue4 !== 1'b1) bad_rb++;
    end
    n_checks++;
    if (fall_at != 3) begin
      n_fail++;
      $display("FAIL green_latency got=%0d required=3", fall_at);
    end
    n_checks++;
    if (bad_rb != 0) begin
      n_fail++;
      $display("FAIL red_blue_hold bad=%0d required=0", bad_rb);
    end
    green = 1'b1;
  endtask

  task automatic test_mid_reset();
    obs_t rv;
    logic found = 1'b0;
    int cyc0, wrap_at = -1, fs_cnt = 0;
    rv = '0; rv.hs = 1'b1; rv.vs = 1'b1;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick_sb();
      if (pixel_tick4 && pixel_x4 == 10'd700) found = 1'b1;
    end
    rst4 = 1'b1;
    tick_sb();
    n_checks++;
    if (!found || obs4() !== rv) begin
      n_fail++;
      $display("FAIL mid_reset_u4 found=%b got=%h required=%h", found, obs4(), rv);
    end
    rst4 = 1'b0;
    tick_sb();
    cyc0 = cyc;
    n_checks++;
    if ({pixel_x4, pixel_y4, video_on4} !== {10'd0, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_u4 x=%0d y=%0d vo=%b required 0 0 1", pixel_x4, pixel_y4, video_on4);
    end
    repeat (3300) begin
      tick_sb();
      if (frame_start4) fs_cnt++;
      if (pixel_tick4 && pixel_x4 == 10'd0 && wrap_at < 0) begin
        wrap_at = cyc - cyc0;
        n_checks++;
        if (pixel_y4 !== 10'd1) begin
          n_fail++;
          $display("FAIL wrap_y_u4 got=%0d required=1", pixel_y4);
        end
      end
    end
    n_checks++;
    if (wrap_at != 3200) begin
      n_fail++;
      $display("FAIL restart_line_u4 got=%0d required=3200", wrap_at);
    end
    n_checks++;
    if (fs_cnt != 0) begin
      n_fail++;
      $display("FAIL no_frame_start_u4 got=%0d required=0", fs_cnt);
    end
  endtask

  task automatic test_clkdiv1();
    logic found = 1'b0;
    int cyc0, wrap_cnt = 0, bad_wrap = 0, bad_pt = 0, fs_cnt = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick_sb();
      if (pixel_x1 == 10'd700) found = 1'b1;
    end
    rst1 = 1'b1;
    tick_sb();
    n_checks++;
    if (!found || {pixel_x1, pixel_y1, h_sync1, v_sync1, video_on1, pixel_tick1} !== {10'd0, 10'd0, 4'b1100}) begin
      n_fail++;
      $display("FAIL mid_reset_u1 found=%b x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b",
               found, pixel_x1, pixel_y1, h_sync1, v_sync1, video_on1, pixel_tick1);
    end
    rst1 = 1'b0;
    tick_sb();
    cyc0 = cyc;
    repeat (1700) begin
      tick_sb();
      if (pixel_tick1 !== 1'b1) bad_pt++;
      if (frame_start1) fs_cnt++;
      if (pixel_x1 == 10'd0) begin
        wrap_cnt++;
        if (cyc - cyc0 != 800 * wrap_cnt) bad_wrap++;
      end
    end
    n_checks++;
    if (bad_pt != 0) begin
      n_fail++;
      $display("FAIL tick_cont_u1 bad=%0d required=0", bad_pt);
    end
    n_checks++;
    if (bad_wrap != 0 || wrap_cnt != 2) begin
      n_fail++;
      $display("FAIL line_u1 bad=%0d wraps=%0d required 0 2", bad_wrap, wrap_cnt);
    end
    n_checks++;
    if (fs_cnt != 0) begin
      n_fail++;
      $display("FAIL no_frame_start_u1 got=%0d required=0", fs_cnt);
    end
  endtask

  task automatic test_frames();
    logic found = 1'b0, vs_prev;
    int cyc0, fs_cnt = 0, fs1 = -1, fs2 = -1, bad_fs = 0;
    int vs_start = -1, vs_runs = 0, bad_vs = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick_sb();
      if (pixel_ys == 10'd5) found = 1'b1;
    end
    rsts = 1'b1;
    tick_sb();
    n_checks++;
    if (!found || {pixel_xs, pixel_ys, v_syncs, frame_starts} !== {10'd0, 10'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL mid_reset_us found=%b x=%0d y=%0d vs=%b fs=%b",
               found, pixel_xs, pixel_ys, v_syncs, frame_starts);
    end
    rsts = 1'b0;
    tick_sb();
    cyc0 = cyc;
    vs_prev = v_syncs;
    repeat (750) begin
      tick_sb();
      if (frame_starts) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = cyc - cyc0; else if (fs2 < 0) fs2 = cyc - cyc0;
        if (!pixel_ticks || pixel_xs != 10'd0 || pixel_ys != 10'd0) bad_fs++;
      end
      if (vs_prev && !v_syncs) begin
        vs_start = cyc;
        if (pixel_ys != 10'd6 || pixel_xs != 10'd0) bad_vs++;
      end
      if (!vs_prev && v_syncs && vs_start >= 0) begin
        vs_runs++;
        if (cyc - vs_start != 60) bad_vs++;
      end
      vs_prev = v_syncs;
    end
    n_checks++;
    if (fs_cnt != 2 || fs1 != 330 || fs2 != 660 || bad_fs != 0) begin
      n_fail++;
      $display("FAIL frame_start cnt=%0d at=%0d,%0d bad=%0d required 2 at 330,660 bad 0",
               fs_cnt, fs1, fs2, bad_fs);
    end
    n_checks++;
    if (vs_runs != 2 || bad_vs != 0) begin
      n_fail++;
      $display("FAIL vsync_pulse runs=%0d bad=%0d required 2 0", vs_runs, bad_vs);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_rgb_boundary();
    test_green_toggle();
    test_mid_reset();
    test_clkdiv1();
    test_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Timing controller that sequences the VGA pixel datapath for 640x480 at 60 Hz from the 100 MHz board clock. It divides the clock into a pixel-rate enable and runs the horizontal and vertical counters. It generates h_sync, v_sync, the visible-area flag and pixel coordinates, and gates the 1-bit colour switch inputs onto Red/Green/Blue so they are zero during blanking. It sits between the board switches and the VGA connector and is the sole source of display timing.

Parameters:
CLK_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz); legal range >=1
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
red  in  1  red colour switch (asynchronous to clk)
green  in  1  green colour switch (asynchronous)
blue  in  1  blue colour switch (asynchronous)
h_sync  out  1  horizontal sync, active low
v_sync  out  1  vertical sync, active low
video_on  out  1  1 while (pixel_x, pixel_y) is in the visible area
pixel_x  out  10  current column, 0..H_TOTAL-1
pixel_y  out  10  current line, 0..V_TOTAL-1
pixel_tick  out  1  one-clk pulse marking the first clk of each new pixel on the outputs
frame_start  out  1  one-clk pulse when outputs present (0,0) after a frame wrap
Red  out  1  gated red
Green  out  1  gated green
Blue  out  1  gated blue

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). The counter width is 10 bits.
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. Internal tick = (div_cnt == CLK_DIV-1). With CLK_DIV=1, tick is 1 every clk.
- On an edge where tick=1:
  - h_cnt increments.
  - At h_cnt == H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt == V_TOTAL-1 on that same wrap, v_cnt wraps to 0.
- Output stage is registered every clk from the current h_cnt/v_cnt. All outputs therefore change together, one clk after the counter update.
  - pixel_x = h_cnt, pixel_y = v_cnt.
  - video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - h_sync = 0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751).
  - v_sync = 0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491).
  - Red/Green/Blue = synchronised switch AND the video_on being registered this same cycle. They are never 1 while video_on is 0.
- tick is delayed by one flop (tick_d1).
  - pixel_tick is registered from tick_d1, so it is high in exactly the clk where pixel_x/pixel_y first show the new value.
  - frame_start is registered from (tick_d1 && h_cnt==0 && v_cnt==0).
- Switch inputs pass through a 2-flop synchroniser. Latency from a switch change to Red/Green/Blue is 3 clks when video_on is 1.
- Reset (synchronous, active high) clears:
  - div_cnt, h_cnt, v_cnt, tick_d1 and the synchroniser flops to 0.
  - Outputs: h_sync=1, v_sync=1, video_on=0, pixel_x=0, pixel_y=0, pixel_tick=0, frame_start=0, Red=Green=Blue=0.
- First clk after reset deasserts: outputs decode (0,0), so video_on=1. RGB reflects the synchroniser, which is still 0 until 2 clks later.
- frame_start is NOT pulsed after reset. The first pulse occurs after one full frame.
- Reset asserted mid-frame aborts the frame immediately. There is no completion of the line or frame, and no extra frame_start pulse.
- If both the h and v wraps occur on the same tick, both counters go to 0 on the same edge.

Test Plan:
- Reset held 3 clks with switches=1,1,0 -> all outputs at their reset values while reset=1. The first clk after release shows pixel_x=0, pixel_y=0, video_on=1, h_sync=1, v_sync=1. Red=1, Green=1, Blue=0 from the 3rd clk after release.
- Free run with CLK_DIV=4 -> pixel_tick period exactly 4 clks. pixel_x steps 0..799 then 0. Line = 3200 clks. h_sync low for exactly 384 clks, beginning on the clk where pixel_x=656.
- Run 2 frames -> v_sync low for 2 lines (pixel_y=490,491; 6400 clks). frame_start pulses once per 1,680,000 clks, coincident with pixel_tick, pixel_x=0, pixel_y=0. No pulse in the first frame after reset.
- Switches=1,1,1 across the x=639->640 and y=479->480 boundaries -> RGB=1 at x=639 and 0 at x=640 in the same clk video_on falls. RGB=0 for all of lines 480..524.
- Toggle green 1->0 mid-line at x=100 -> Green falls exactly 3 clks later. red/blue are unaffected.
- Assert reset for 1 clk at pixel (700,300) -> the next clk shows reset values. Counting restarts from (0,0) and no frame_start appears. Repeat with CLK_DIV=1 -> pixel_tick is continuously 1 and the line is 800 clks.
